pixel_plot_arbiter: RTL and testbench



---
 rtl/pixel_plot_if.sv | 39 +++
 rtl/pixel_plot_arbiter.sv | 138 +++++++++++++
 tb/tb_pixel_plot_arbiter.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_plot_if.sv
// Pixel-write bus between the two drawing clients, the plot arbiter and the VGA adapter.
// slave = arbiter side, master = client/adapter side.
interface pixel_plot_if;
    logic       clear_req;
    logic       c0_valid;
    logic [7:0] c0_x;
    logic [6:0] c0_y;
    logic [2:0] c0_colour;
    logic       c0_ready;
    logic       c1_valid;
    logic [7:0] c1_x;
    logic [6:0] c1_y;
    logic [2:0] c1_colour;
    logic       c1_ready;
    logic       plot;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       clear_done;
    logic [7:0] drop_count;

    modport slave (
        input  clear_req,
        input  c0_valid, c0_x, c0_y, c0_colour,
        output c0_ready,
        input  c1_valid, c1_x, c1_y, c1_colour,
        output c1_ready,
        output plot, x, y, colour, clear_done, drop_count
    );

    modport master (
        output clear_req,
        output c0_valid, c0_x, c0_y, c0_colour,
        input  c0_ready,
        output c1_valid, c1_x, c1_y, c1_colour,
        input  c1_ready,
        input  plot, x, y, colour, clear_done, drop_count
    );
endinterface

// File: rtl/pixel_plot_arbiter.sv
// Round-robin arbiter merging paddle/ball pixel writes into one plot stream; owns screen clearing.
// Latency: 1 cycle from accepted pixel to registered plot output. Optional macro PLOT_BOUNDS_CHECK_EN.
// Backpressure: both readys low during a clear sweep and on a clear_req cycle; one ready per cycle otherwise.
module pixel_plot_arbiter #(
    parameter int         SCREEN_W  = 160,
    parameter int         SCREEN_H  = 120,
    parameter logic [2:0] BG_COLOUR = 3'b000
) (
    input  logic          clock,
    input  logic          resetn,
    pixel_plot_if.slave   bus
);

    localparam logic [7:0] X_LAST = 8'(SCREEN_W - 1);
    localparam logic [6:0] Y_LAST = 7'(SCREEN_H - 1);

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    logic [0:0] state;
    logic [7:0] cx;
    logic [6:0] cy;
    logic       last_grant;

    logic       plot_q;
    logic [7:0] x_q;
    logic [6:0] y_q;
    logic [2:0] colour_q;
    logic       done_q;
    logic [7:0] drop_q;

    logic       rdy0;
    logic       rdy1;
    logic       xfer;
    logic [7:0] gx;
    logic [6:0] gy;
    logic [2:0] gc;
    logic       in_range;

    // last_grant=1 means client 1 won last, so client 0 wins the next tie
    always_comb begin
        rdy0 = 1'b0;
        rdy1 = 1'b0;
        if (state == ST_RUN && !bus.clear_req) begin
            if (bus.c0_valid && bus.c1_valid) begin
                rdy0 = last_grant;
                rdy1 = ~last_grant;
            end else begin
                rdy0 = bus.c0_valid;
                rdy1 = bus.c1_valid;
            end
        end
    end

    assign xfer = rdy0 | rdy1;
    assign gx   = rdy1 ? bus.c1_x      : bus.c0_x;
    assign gy   = rdy1 ? bus.c1_y      : bus.c0_y;
    assign gc   = rdy1 ? bus.c1_colour : bus.c0_colour;

`ifdef PLOT_BOUNDS_CHECK_EN
    assign in_range = (gx <= X_LAST) && (gy <= Y_LAST);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            drop_q <= 8'd0;
        end else if (state == ST_RUN && !bus.clear_req && xfer && !in_range && drop_q != 8'hFF) begin
            drop_q <= drop_q + 8'd1;
        end
    end
`else
    assign in_range = 1'b1;
    assign drop_q   = 8'd0;
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_CLEAR;
            cx         <= 8'd0;
            cy         <= 7'd0;
            last_grant <= 1'b1;
            plot_q     <= 1'b0;
            x_q        <= 8'd0;
            y_q        <= 7'd0;
            colour_q   <= 3'd0;
            done_q     <= 1'b0;
        end else begin
            plot_q <= 1'b0;
            done_q <= 1'b0;
            case (state)
                ST_CLEAR: begin
                    plot_q   <= 1'b1;
                    x_q      <= cx;
                    y_q      <= cy;
                    colour_q <= BG_COLOUR;
                    if (cx == X_LAST) begin
                        cx <= 8'd0;
                        if (cy == Y_LAST) begin
                            cy     <= 7'd0;
                            state  <= ST_RUN;
                            done_q <= 1'b1;
                        end else begin
                            cy <= cy + 7'd1;
                        end
                    end else begin
                        cx <= cx + 8'd1;
                    end
                end
                ST_RUN: begin
                    if (bus.clear_req) begin
                        state <= ST_CLEAR;
                        cx    <= 8'd0;
                        cy    <= 7'd0;
                    end else if (xfer) begin
                        last_grant <= rdy1;
                        // out-of-range pixels are consumed but leave the output holding
                        if (in_range) begin
                            plot_q   <= 1'b1;
                            x_q      <= gx;
                            y_q      <= gy;
                            colour_q <= gc;
                        end
                    end
                end
                default: state <= ST_CLEAR;
            endcase
        end
    end

    assign bus.c0_ready   = rdy0;
    assign bus.c1_ready   = rdy1;
    assign bus.plot       = plot_q;
    assign bus.x          = x_q;
    assign bus.y          = y_q;
    assign bus.colour     = colour_q;
    assign bus.clear_done = done_q;
    assign bus.drop_count = drop_q;

endmodule

// File: tb/tb_pixel_plot_arbiter.sv
// Scoreboard bench for pixel_plot_arbiter: a cycle-count reference model pushes expected plots
// (with due cycle) and a separate monitor pops and compares whenever plot is high.
module tb_pixel_plot_arbiter;

    localparam int W  = 160;
    localparam int H  = 120;
    localparam int WH = W * H;

    typedef struct {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
        int         due;
    } exp_t;

    logic clock = 1'b0;
    logic resetn = 1'b0;
    pixel_plot_if bus();

    pixel_plot_arbiter dut (.clock(clock), .resetn(resetn), .bus(bus));

    always #5 clock = ~clock;

    int   cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    int   sweep_left = 0;
    bit   need_reset_sweep = 1'b0;
    int   done_due = -1;
    bit   last_m = 1'b1;
    int   drop_m = 0;
    bit   t0, t1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic start_sweep(input int base);
        for (int yy = 0; yy < H; yy++)
            for (int xx = 0; xx < W; xx++)
                sb.push_back('{x: 8'(xx), y: 7'(yy), c: 3'b000, due: base + yy * W + xx});
        done_due = base + WH - 1;
    endtask

    // Reference: sweep is a countdown of WH load cycles; RUN is plain round-robin.
    task automatic model_step();
        int  n;
        bit  e0, e1;
        logic [7:0] px;
        logic [6:0] py;
        logic [2:0] pc;
        n  = cyc;
        e0 = 1'b0;
        e1 = 1'b0;
        chk("drop_count", 32'(bus.drop_count), 32'(drop_m));
        if (need_reset_sweep) begin
            start_sweep(n + 1);
            sweep_left = WH;
            need_reset_sweep = 1'b0;
        end
        if (sweep_left > 0) begin
            sweep_left--;
        end else if (bus.clear_req) begin
            start_sweep(n + 2);
            sweep_left = WH;
        end else if (bus.c0_valid && bus.c1_valid) begin
            e0 = last_m;
            e1 = !last_m;
        end else begin
            e0 = bus.c0_valid;
            e1 = bus.c1_valid;
        end
        chk("c0_ready", 32'(bus.c0_ready), 32'(e0));
        chk("c1_ready", 32'(bus.c1_ready), 32'(e1));
        t0 = e0;
        t1 = e1;
        if (e0 || e1) begin
            last_m = e1;
            px = e1 ? bus.c1_x : bus.c0_x;
            py = e1 ? bus.c1_y : bus.c0_y;
            pc = e1 ? bus.c1_colour : bus.c0_colour;
`ifdef PLOT_BOUNDS_CHECK_EN
            if (int'(px) >= W || int'(py) >= H) begin
                if (drop_m < 255) drop_m++;
            end else
`endif
                sb.push_back('{x: px, y: py, c: pc, due: n + 1});
        end
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (resetn) begin
            if (bus.plot) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL plot_unexpected: got (%0d,%0d,%0d) at cycle %0d, expected no plot",
                             bus.x, bus.y, bus.colour, cyc);
                end else begin
                    e = sb.pop_front();
                    if (bus.x !== e.x || bus.y !== e.y || bus.colour !== e.c || cyc != e.due) begin
                        errors++;
                        $display("FAIL plot_pixel: got (%0d,%0d,%0d)@%0d expected (%0d,%0d,%0d)@%0d",
                                 bus.x, bus.y, bus.colour, cyc, e.x, e.y, e.c, e.due);
                    end
                end
            end else if (sb.size() > 0 && sb[0].due <= cyc) begin
                checks++;
                errors++;
                $display("FAIL plot_missing: got plot=0 at cycle %0d expected (%0d,%0d,%0d)",
                         cyc, sb[0].x, sb[0].y, sb[0].c);
                void'(sb.pop_front());
            end
            if (bus.clear_done || cyc == done_due)
                chk("clear_done", 32'(bus.clear_done), 32'(cyc == done_due));
        end
    end

    task automatic step();
        @(negedge clock);
        model_step();
        @(posedge clock);
        #1;
        bus.clear_req = 1'b0;
    endtask

    task automatic do_reset();
        bus.c0_valid  = 1'b0;
        bus.c1_valid  = 1'b0;
        bus.clear_req = 1'b0;
        resetn = 1'b0;
        #1;
        chk("rst_plot", 32'(bus.plot), 0);
        chk("rst_x", 32'(bus.x), 0);
        chk("rst_y", 32'(bus.y), 0);
        chk("rst_colour", 32'(bus.colour), 0);
        chk("rst_clear_done", 32'(bus.clear_done), 0);
        chk("rst_drop_count", 32'(bus.drop_count), 0);
        chk("rst_c0_ready", 32'(bus.c0_ready), 0);
        chk("rst_c1_ready", 32'(bus.c1_ready), 0);
        sb.delete();
        sweep_left = 0;
        done_due = -1;
        last_m = 1'b1;
        drop_m = 0;
        @(posedge clock);
        #1;
        resetn = 1'b1;
        need_reset_sweep = 1'b1;
    endtask

    task automatic wait_idle(input string name, input int budget);
        while ((sweep_left > 0 || need_reset_sweep || sb.size() > 0) && budget > 0) begin
            step();
            budget--;
        end
        checks++;
        if (budget == 0) begin
            errors++;
            $display("FAIL %s_timeout: got still busy, expected idle within budget", name);
        end
    endtask

    task automatic set_c0(input bit v, input int xx, input int yy, input int cc);
        bus.c0_valid = v; bus.c0_x = 8'(xx); bus.c0_y = 7'(yy); bus.c0_colour = 3'(cc);
    endtask

    task automatic set_c1(input bit v, input int xx, input int yy, input int cc);
        bus.c1_valid = v; bus.c1_x = 8'(xx); bus.c1_y = 7'(yy); bus.c1_colour = 3'(cc);
    endtask

    function automatic int rnd_x();
        return ($urandom_range(0, 3) == 0) ? int'($urandom_range(160, 255)) : int'($urandom_range(0, 159));
    endfunction

    function automatic int rnd_y();
        return ($urandom_range(0, 3) == 0) ? int'($urandom_range(120, 127)) : int'($urandom_range(0, 119));
    endfunction

    initial begin
        int budget;
        set_c0(1'b0, 0, 0, 0);
        set_c1(1'b0, 0, 0, 0);
        bus.clear_req = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        do_reset();

        // power-up sweep, with a clear_req mid-sweep that must be ignored
        for (int i = 0; i < 100; i++) step();
        bus.clear_req = 1'b1;
        wait_idle("first_sweep", 25000);

        // both clients held for 4 cycles: grants alternate starting with c0
        set_c0(1'b1, 53, 119, 3'b111);
        set_c1(1'b1, 80, 40, 3'b010);
        for (int i = 0; i < 4; i++) step();
        set_c0(1'b0, 0, 0, 0);
        set_c1(1'b0, 0, 0, 0);
        step();

        set_c0(1'b1, 60, 119, 3'b111);
        step();
        set_c0(1'b0, 0, 0, 0);
        step();

        for (int i = 0; i < 400; i++) begin
            step();
            if (!bus.c0_valid || t0) set_c0(1'($urandom_range(0, 1)), rnd_x(), rnd_y(), int'($urandom_range(0, 7)));
            if (!bus.c1_valid || t1) set_c1(1'($urandom_range(0, 1)), rnd_x(), rnd_y(), int'($urandom_range(0, 7)));
        end
        budget = 50;
        while ((bus.c0_valid || bus.c1_valid) && budget > 0) begin
            step();
            if (t0) bus.c0_valid = 1'b0;
            if (t1) bus.c1_valid = 1'b0;
            budget--;
        end
        chk("drain_valids", 32'(bus.c0_valid | bus.c1_valid), 0);
        wait_idle("drain", 10);

        // clear_req coinciding with c1_valid: c1 waits out the whole sweep
        set_c1(1'b1, 30, 20, 3'b101);
        bus.clear_req = 1'b1;
        budget = 25000;
        t1 = 1'b0;
        do begin
            step();
            budget--;
        end while (!t1 && budget > 0);
        chk("c1_after_clear", 32'(t1), 1);
        set_c1(1'b0, 0, 0, 0);
        wait_idle("clear_sweep", 10);

        set_c0(1'b1, 160, 10, 3'b111);
        step();
        set_c0(1'b1, 159, 119, 3'b111);
        step();
        set_c0(1'b0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step();
`ifdef PLOT_BOUNDS_CHECK_EN
        chk("drop_after_oob", 32'(bus.drop_count), 32'(drop_m > 0 ? drop_m : 1));
`else
        chk("drop_after_oob", 32'(bus.drop_count), 0);
`endif

        // reset while the sweep is at pixel (10,5)
        bus.clear_req = 1'b1;
        step();
        budget = 2000;
        while (sweep_left != WH - (5 * W + 10 + 1) && budget > 0) begin
            step();
            budget--;
        end
        chk("reach_10_5", 32'(sweep_left), 32'(WH - (5 * W + 10 + 1)));
        do_reset();
        wait_idle("restart_sweep", 25000);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
